// File: rtl/dwt97_inverse_pkg.sv
// Shared types and coefficient helpers for the inverse 9/7 lifting datapath.
// Fixed-point coefficients are truncated toward zero, so the defaults give -1624 and -54.
package dwt97_inverse_pkg;

  localparam real CoefAlpha     = -1.586134342059924;
  localparam real CoefBeta      = -0.052980118572961;
  localparam int  PairDataWidth = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic                     eol;
    logic                     sof;
    logic [PairDataWidth-1:0] hi;
    logic [PairDataWidth-1:0] lo;
  } pair_t;

  typedef struct packed {
    logic                     sof;
    logic [PairDataWidth-1:0] e;
    logic [PairDataWidth-1:0] d;
  } pend_t;

  function automatic real fixed_scale(input int point);
    real scale;
    scale = 1.0;
    for (int i = 0; i < point; i++) begin
      scale = scale * 2.0;
    end
    return scale;
  endfunction

  function automatic int int_alpha(input real alpha, input int point);
    return $rtoi(alpha * fixed_scale(point));
  endfunction

  function automatic int int_beta(input real beta, input int point);
    return $rtoi(beta * fixed_scale(point));
  endfunction

endpackage

// File: rtl/inverse_processing_unit_1d_lift.sv
// Combinational lifting step y = a - (((b + c) * K) >>> Point), wrapping to DataWidth.
module inverse_lift_step #(
  parameter int DataWidth = 16,
  parameter int Point     = 10,
  parameter int Coef      = 0
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] y_o
);

  localparam int ProdWidth = DataWidth + 33;
  localparam logic signed [ProdWidth-1:0] CoefExt = ProdWidth'(Coef);

  logic signed [DataWidth:0]   sum_s;
  logic signed [ProdWidth-1:0] prod_s;

  assign sum_s  = $signed({b_i[DataWidth-1], b_i}) + $signed({c_i[DataWidth-1], c_i});
  assign prod_s = ProdWidth'(sum_s) * CoefExt;
  // Arithmetic shift floors; the final truncation gives wrap-around without saturation.
  assign y_o    = a_i - DataWidth'(prod_s >>> Point);

endmodule

// File: rtl/inverse_processing_unit_1d.sv
// Inverse 9/7 lifting for one line direction: undoes beta then alpha on {high, low} pairs,
// producing {odd, even} pairs with sof/eol framing; each pair waits for its right neighbour.
module inverse_processing_unit_1d
  import dwt97_inverse_pkg::*;
#(
  parameter int  DataWidth = 16,
  parameter int  Point     = 10,
  parameter real Alpha     = CoefAlpha,
  parameter real Beta      = CoefBeta,
  parameter bit  InputReg  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int IntAlpha = int_alpha(Alpha, Point);
  localparam int IntBeta  = int_beta(Beta, Point);

  state_e state_q, state_d;
  logic   alive_q;

  logic                   core_valid_s, core_sof_s, core_eol_s;
  logic [2*DataWidth-1:0] core_data_s;
  logic                   core_ready_s, out_free_s, accept_s, emit_s, last_s;
  logic [DataWidth-1:0]   in_hi_s, in_lo_s, beta_b_s, e_new_s, alpha_c_s, odd_s;

  logic [DataWidth-1:0]   d_prev_q, pend_e_q, pend_d_q;
  logic                   pend_sof_q;
  logic                   m_valid_q, m_sof_q, m_eol_q;
  logic [2*DataWidth-1:0] m_data_q;

  // Ready stays low through reset and for the first edge after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end

  assign out_free_s   = ~m_valid_q | m_ready_i;
  assign core_ready_s = alive_q & (state_q != FLUSH) & out_free_s;
  assign s_ready_o    = core_ready_s;
  assign accept_s     = core_valid_s & core_ready_s;

  if (InputReg) begin : g_in_reg
    logic                   in_valid_q, in_sof_q, in_eol_q;
    logic [2*DataWidth-1:0] in_data_q;

    // Input pipeline stage advances in lock-step with the core.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        in_valid_q <= 1'b0;
        in_sof_q   <= 1'b0;
        in_eol_q   <= 1'b0;
        in_data_q  <= {(2*DataWidth){1'b0}};
      end else if (core_ready_s) begin
        in_valid_q <= s_valid_i;
        in_sof_q   <= s_sof_i;
        in_eol_q   <= s_eol_i;
        in_data_q  <= s_data_i;
      end
    end

    assign core_valid_s = in_valid_q;
    assign core_sof_s   = in_sof_q;
    assign core_eol_s   = in_eol_q;
    assign core_data_s  = in_data_q;
  end else begin : g_in_pass
    assign core_valid_s = s_valid_i;
    assign core_sof_s   = s_sof_i;
    assign core_eol_s   = s_eol_i;
    assign core_data_s  = s_data_i;
  end

  assign {in_hi_s, in_lo_s} = core_data_s;
  assign beta_b_s           = core_sof_s ? in_hi_s : d_prev_q;

  inverse_lift_step #(.DataWidth(DataWidth), .Point(Point), .Coef(IntBeta)) u_beta (
    .a_i (in_lo_s),
    .b_i (beta_b_s),
    .c_i (in_hi_s),
    .y_o (e_new_s)
  );

  inverse_lift_step #(.DataWidth(DataWidth), .Point(Point), .Coef(IntAlpha)) u_alpha (
    .a_i (pend_d_q),
    .b_i (pend_e_q),
    .c_i (alpha_c_s),
    .y_o (odd_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an sof beat while holding simply restarts the line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, HOLD: begin
        if (accept_s) begin
          if (core_eol_s) begin
            state_d = FLUSH;
          end else begin
            state_d = HOLD;
          end
        end else begin
          state_d = state_q;
        end
      end
      FLUSH: begin
        if (out_free_s) begin
          state_d = EMPTY;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Emission control; the flush beat reuses the last e as its own right neighbour.
  always_comb begin
    emit_s    = 1'b0;
    last_s    = 1'b0;
    alpha_c_s = e_new_s;
    case (state_q)
      EMPTY: begin
        emit_s = 1'b0;
      end
      HOLD: begin
        emit_s = accept_s & ~core_sof_s;
      end
      FLUSH: begin
        emit_s    = out_free_s;
        last_s    = 1'b1;
        alpha_c_s = pend_e_q;
      end
      default: begin
        emit_s = 1'b0;
      end
    endcase
  end

  // Line state: previous d and the pair waiting for its successor.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_prev_q   <= {DataWidth{1'b0}};
      pend_e_q   <= {DataWidth{1'b0}};
      pend_d_q   <= {DataWidth{1'b0}};
      pend_sof_q <= 1'b0;
    end else if (accept_s) begin
      d_prev_q   <= in_hi_s;
      pend_e_q   <= e_new_s;
      pend_d_q   <= in_hi_s;
      pend_sof_q <= core_sof_s;
    end
  end

  // Output register: holds while stalled, reloads in the cycle the current beat leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_data_q  <= {(2*DataWidth){1'b0}};
    end else if (emit_s) begin
      m_valid_q <= 1'b1;
      m_sof_q   <= pend_sof_q;
      m_eol_q   <= last_s;
      m_data_q  <= {odd_s, pend_e_q};
    end else if (m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_inverse_processing_unit_1d.sv
// Self-checking bench for inverse_processing_unit_1d against a per-line arithmetic model.
module tb_inverse_processing_unit_1d;

  localparam int  PT     = 10;
  localparam real BetaR  = -0.052980118572961;
  localparam real AlphaR = -1.586134342059924;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s_ready_o, s_valid_i, s_sof_i, s_eol_i;
  logic [31:0] s_data_i;
  logic        m_ready_i, m_valid_o, m_sof_o, m_eol_o;
  logic [31:0] m_data_o;

  int tests_run = 0;
  int tests_failed = 0;
  int stab_err = 0;
  int stall_cnt = 0;
  int k_beta, k_alpha;

  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  logic        held_q = 1'b0;
  logic [33:0] held_beat_q = 34'd0;

  inverse_processing_unit_1d dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_ready_o (s_ready_o),
    .s_valid_i (s_valid_i),
    .s_sof_i   (s_sof_i),
    .s_eol_i   (s_eol_i),
    .s_data_i  (s_data_i),
    .m_ready_i (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_sof_o   (m_sof_o),
    .m_eol_o   (m_eol_o),
    .m_data_o  (m_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Output monitor: records completed beats and checks stability while stalled.
  always @(negedge clk_i) begin
    if (rst_i) begin
      held_q <= 1'b0;
    end else begin
      if (held_q && (!m_valid_o || {m_eol_o, m_sof_o, m_data_o} !== held_beat_q))
        stab_err <= stab_err + 1;
      if (m_valid_o && !m_ready_i) stall_cnt <= stall_cnt + 1;
      if (m_valid_o && m_ready_i) got_q.push_back({m_eol_o, m_sof_o, m_data_o});
      held_q      <= m_valid_o && !m_ready_i;
      held_beat_q <= {m_eol_o, m_sof_o, m_data_o};
    end
  end

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // a - floor((b + c) * k / 2^PT), wrapped to 16 bits
  function automatic logic [15:0] lift(input int a, input int b, input int c, input int k);
    real    t;
    longint q, r;
    t = real'((b + c) * k) / real'(1 << PT);
    q = longint'($floor(t));
    r = longint'(a) - q;
    return r[15:0];
  endfunction

  task automatic model_line(input logic [15:0] s_a[$], input logic [15:0] d_a[$]);
    int n;
    int e[$];
    n = s_a.size();
    for (int i = 0; i < n; i++) begin
      int dp;
      dp = (i == 0) ? sx(d_a[0]) : sx(d_a[i-1]);
      e.push_back(sx(lift(sx(s_a[i]), dp, sx(d_a[i]), k_beta)));
    end
    for (int i = 0; i < n; i++) begin
      int          en;
      logic [15:0] odd;
      en  = (i == n - 1) ? e[i] : e[i+1];
      odd = lift(sx(d_a[i]), e[i], en, k_alpha);
      exp_q.push_back({(i == n - 1), (i == 0), odd, 16'(e[i])});
    end
  endtask

  task automatic send_line(input logic [15:0] s_a[$], input logic [15:0] d_a[$],
                           input int max_gap, input bit close);
    int n;
    n = s_a.size();
    for (int i = 0; i < n; i++) begin
      int g, cyc;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      s_valid_i = 1'b0;
      repeat (g) begin
        @(posedge clk_i);
        #1;
      end
      s_valid_i = 1'b1;
      s_sof_i   = (i == 0);
      s_eol_i   = close && (i == n - 1);
      s_data_i  = {d_a[i], s_a[i]};
      cyc = 0;
      @(negedge clk_i);
      while (!s_ready_o && cyc < 200) begin
        @(negedge clk_i);
        cyc++;
      end
      if (!s_ready_o) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_timeout: beat %0d never accepted, s_ready_o=%b required 1", i, s_ready_o);
      end
      @(posedge clk_i);
      #1;
    end
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 1000) begin
      @(posedge clk_i);
      cyc++;
    end
    repeat (8) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #2;
    tests_run++;
    if ({s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_data_o} !== 36'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b v=%b sof=%b eol=%b data=%h required all 0",
               s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_data_o);
    end
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    tests_run++;
    if (s_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_early: got %b required 0", s_ready_o);
    end
    @(posedge clk_i);
    #1;
    tests_run++;
    if (s_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after: got %b required 1", s_ready_o);
    end
  endtask

  task automatic test_one_pair();
    logic [15:0] sq[$], dq[$];
    int low;
    sq.push_back(16'd1024);
    dq.push_back(16'd0);
    exp_q.push_back({1'b1, 1'b1, 16'd3248, 16'd1024});
    send_line(sq, dq, 0, 1'b1);
    low = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (!s_ready_o) low++;
    end
    tests_run++;
    if (low != 1) begin
      tests_failed++;
      $display("FAIL one_pair_ready_low: got %0d low cycles required 1", low);
    end
    wait_drain();
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL one_pair_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL one_pair_beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_constant_line();
    logic [15:0] sq[$], dq[$];
    for (int i = 0; i < 4; i++) begin
      sq.push_back(16'd0);
      dq.push_back(16'd1024);
      exp_q.push_back({(i == 3), (i == 0), 16'd1367, 16'd108});
    end
    send_line(sq, dq, 0, 1'b1);
    wait_drain();
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL const_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL const_beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [15:0] sq[$], dq[$];
    int err0, stall0;
    for (int i = 0; i < 8; i++) begin
      sq.push_back(16'($urandom));
      dq.push_back(16'($urandom));
    end
    model_line(sq, dq);
    err0   = stab_err;
    stall0 = stall_cnt;
    fork
      send_line(sq, dq, 0, 1'b1);
      begin
        repeat (4) @(posedge clk_i);
        #1 m_ready_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 m_ready_i = 1'b1;
      end
    join
    wait_drain();
    tests_run++;
    if (stall_cnt - stall0 < 4) begin
      tests_failed++;
      $display("FAIL bp_stalled: got %0d stalled cycles required at least 4", stall_cnt - stall0);
    end
    tests_run++;
    if (stab_err != err0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d unstable cycles required 0", stab_err - err0);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL bp_beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_lines();
    int err0;
    err0 = stab_err;
    fork
      begin
        for (int l = 0; l < 4; l++) begin
          logic [15:0] sq[$], dq[$];
          int n;
          n = (l == 0) ? 1 : int'($urandom_range(12, 2));
          for (int i = 0; i < n; i++) begin
            sq.push_back(16'($urandom));
            dq.push_back(16'($urandom));
          end
          model_line(sq, dq);
          send_line(sq, dq, 2, 1'b1);
        end
      end
      begin
        repeat (120) begin
          @(posedge clk_i);
          #1 m_ready_i = ($urandom_range(3, 0) != 0);
        end
        m_ready_i = 1'b1;
      end
    join
    wait_drain();
    tests_run++;
    if (stab_err != err0) begin
      tests_failed++;
      $display("FAIL rand_stable: got %0d unstable cycles required 0", stab_err - err0);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rand_beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midline();
    logic [15:0] sq[$], dq[$], s2[$], d2[$];
    sq.push_back(16'd1024); dq.push_back(16'd1024);
    sq.push_back(16'd2000); dq.push_back(16'd500);
    sq.push_back(16'd300);  dq.push_back(16'd7);
    m_ready_i = 1'b0;
    send_line(sq, dq, 0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    tests_run++;
    if (m_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre_valid: got %b required 1", m_valid_o);
    end
    #2 rst_i = 1'b1;
    #1;
    tests_run++;
    if ({s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_data_o} !== 36'd0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got rdy=%b v=%b sof=%b eol=%b data=%h required all 0",
               s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_data_o);
    end
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    m_ready_i = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      s2.push_back(16'($urandom));
      d2.push_back(16'($urandom));
    end
    model_line(s2, d2);
    send_line(s2, d2, 1, 1'b1);
    wait_drain();
    tests_run++;
    if (got_q.size() != 2) begin
      tests_failed++;
      $display("FAIL midrst_count: got %0d beats required 2", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL midrst_beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    k_beta    = $rtoi(BetaR * real'(1 << PT));
    k_alpha   = $rtoi(AlphaR * real'(1 << PT));
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = 32'd0;
    m_ready_i = 1'b1;
    test_reset();
    test_one_pair();
    test_constant_line();
    test_backpressure();
    test_random_lines();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
